soc_system_status_capture: RTL
==============================

# soc_system_status_capture

Parametrised successor to the system's input-only status PIO. It is an Avalon-MM slave in the HPS-to-FPGA lightweight bridge that samples a status bus of up to 32 bits through a configurable synchroniser. It latches selected edges per bit into a sticky capture register, counts edge events, and raises a maskable level interrupt to the HPS.

## Interface
Parameters:
- WIDTH, 32: status bus width, 1..32; unused readdata bits read 0.
- SYNC_STAGES, 2: synchroniser flops on in_port, 2..4.
- EDGE_TYPE, 0: edge detected per bit. 0 = rising, 1 = falling, 2 = any.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset, asserts immediately; deassertion is synchronised externally.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous status inputs.
- irq  out  1  level interrupt.

## Operation
Register map:
- Address 0 DATA (RO): synchronised in_port (s), zero-extended. Writes are ignored.
- Address 1 MASK (RW): irq_mask[WIDTH-1:0].
- Address 2 COUNT (RW): 32-bit event counter. Any write clears it.
- Address 3 CAPTURE (RW1C): sticky edge_capture[WIDTH-1:0]. Writing 1 to a bit clears it; writing 0 leaves it unchanged.

Datapath:
- sync chain of SYNC_STAGES flops; s = last stage; prev <= s every cycle.
- Per-bit edge vector e: rising = s & ~prev; falling = ~s & prev; any = s ^ prev.
- Warm-up counter: counts 0..SYNC_STAGES+1 after reset, then holds. e is forced to 0 until the count reaches SYNC_STAGES+1, so a high input at reset produces no spurious capture.
- Capture update: edge_capture <= (edge_capture & ~clr) | e. Set beats clear on the same bit in the same cycle.
- COUNT increments by 1 on every cycle with e != 0, whether or not the bits were already captured. One cycle with several bits set counts once. Wraps 0xFFFFFFFF -> 0.
- If a COUNT-clear write and an increment occur in the same cycle, the result is 1.
- irq = |(edge_capture & irq_mask), driven from registers only, no combinational path from the bus.
- readdata <= mux(address) every cycle, independent of chipselect, as a zero-wait-state read.

Reset values: readdata 0, irq 0, sync chain 0, prev 0, irq_mask 0, COUNT 0, edge_capture 0, warm-up count 0.

## Timing
- Read latency is 1 cycle: address presented at edge n gives readdata valid after edge n+1.
- Write takes effect at the edge where it is sampled. A read of the same register issued in the next cycle returns the new value.
- An in_port change set up before edge k appears in s after edge k+SYNC_STAGES-1. It is captured into edge_capture, COUNT and DATA-readable state at edge k+SYNC_STAGES, and irq asserts at edge k+SYNC_STAGES if the bit is masked in.
- Pulses shorter than one clk period may be missed. This is by design.
- Reset asserted mid-operation clears everything immediately, and the warm-up restarts.
- Bits at or above WIDTH of MASK/CAPTURE writes are ignored and read as 0.

## Test plan
- Reset with in_port=0xFFFFFFFF held high, then wait 10 cycles -> CAPTURE=0, COUNT=0, irq=0, DATA reads 0xFFFFFFFF.
- EDGE_TYPE=0, SYNC_STAGES=2: drive bit 3 0->1 before edge k -> CAPTURE=0x8 latched at edge k+2, COUNT=1. MASK=0 gives irq=0; write MASK=0x8 -> irq=1 the cycle after the write.
- Write CAPTURE=0x8 in the same cycle a new rising edge on bit 3 is detected -> bit 3 stays 1. A later write of 0x8 with no edge -> CAPTURE=0, irq=0.
- EDGE_TYPE=2: toggle bits 0 and 5 simultaneously, then bit 0 alone -> CAPTURE=0x21, COUNT=2.
- Preload COUNT to 0xFFFFFFFF via 0xFFFFFFFF edge events (force in sim) and apply one more edge -> COUNT=0. Write COUNT together with an edge -> COUNT=1.
- WIDTH=8: write MASK=0xFFFF -> reads 0x000000FF. Assert reset_n=0 mid-operation -> all registers and irq go to 0 asynchronously.

Source files
------------

// File: rtl/soc_system_status_capture_if.sv
// Avalon-MM slave bus bundle for the status capture block.
// Zero-wait-state reads: readdata is registered by the slave.
interface soc_system_status_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_status_capture.sv
// Status input port: synchroniser, per-bit edge capture (RW1C), edge event counter
// and a maskable level interrupt, exposed as a 4-word Avalon-MM slave.
module soc_system_status_capture #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  soc_system_status_capture_if.slave bus,
  input  logic [WIDTH-1:0]           in_port,
  output logic                       irq
);

  localparam int unsigned WarmMax = SYNC_STAGES + 1;
  localparam int unsigned WarmW   = $clog2(WarmMax + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [WarmW-1:0]                  warm_q, warm_d;
  logic [WIDTH-1:0]                  mask_q, mask_d;
  logic [WIDTH-1:0]                  cap_q, cap_d;
  logic [31:0]                       count_q, count_d;
  logic [31:0]                       rdata_q, rdata_d;
  logic                              irq_q, irq_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] ev_raw;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] clr;
  logic             warm_done;
  logic             wr;
  logic             inc;

  assign s         = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WarmW'(WarmMax));
  assign wr        = bus.chipselect & ~bus.write_n;
  assign wdata_w   = bus.writedata[WIDTH-1:0];

  always_comb begin
    ev_raw = s & ~prev_q;
    if (EDGE_TYPE == 1) begin
      ev_raw = ~s & prev_q;
    end else if (EDGE_TYPE == 2) begin
      ev_raw = s ^ prev_q;
    end
  end

  // Suppress edges until the synchroniser and prev have been filled from live input.
  assign ev  = warm_done ? ev_raw : '0;
  assign inc = |ev;

  always_comb begin
    warm_d  = warm_done ? warm_q : warm_q + WarmW'(1);
    clr     = (wr && bus.address == 2'd3) ? wdata_w : '0;
    cap_d   = (cap_q & ~clr) | ev;
    mask_d  = (wr && bus.address == 2'd1) ? wdata_w : mask_q;
    count_d = (wr && bus.address == 2'd2) ? 32'(inc) : count_q + 32'(inc);
    irq_d   = |(cap_d & mask_d);
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      2'd0:    rdata_d[WIDTH-1:0] = s;
      2'd1:    rdata_d[WIDTH-1:0] = mask_q;
      2'd2:    rdata_d            = count_q;
      default: rdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
      mask_q  <= '0;
      cap_q   <= '0;
      count_q <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q  <= s;
      warm_q  <= warm_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule
